// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: instruction fetch, data access and a background bulk clear
// share one memory interface. Each grant is a one-cycle registered memory transaction.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 2,
  parameter int unsigned LEN_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_valid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_done,
  input  logic             clr_start,
  input  logic [31:0]      clr_base,
  input  logic [LEN_W-1:0] clr_len,
  output logic             clr_busy,
  output logic [31:0]      ReadPC,
  output logic [31:0]      ReadWriteAddr,
  output logic [31:0]      DataWrite,
  output logic             Op2En,
  output logic [1:0]       Op2RW,
  input  logic [31:0]      Instruction,
  input  logic [31:0]      Data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 2);

  logic [1:0]          state;
  logic [1:0]          next_state;
  logic [STARVE_W-1:0] starve;
  logic [31:0]         clr_ptr;
  logic [LEN_W-1:0]    clr_cnt;

  // Requests are sampled as levels on every edge; a request still high on the edge its
  // previous access completes is taken as the next request (back-to-back grants).
  always_comb begin
    next_state = IDLE;
    if (if_req && (starve == STARVE_W'(STARVE_MAX)))
      next_state = FETCH;
    else if (d_req)
      next_state = DATA;
    else if (clr_busy)
      next_state = CLEAR;
    else if (if_req)
      next_state = FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      starve        <= '0;
      clr_ptr       <= '0;
      clr_cnt       <= '0;
      clr_busy      <= 1'b0;
      if_valid      <= 1'b0;
      if_rdata      <= '0;
      d_done        <= 1'b0;
      d_rdata       <= '0;
      ReadPC        <= '0;
      ReadWriteAddr <= '0;
      DataWrite     <= '0;
      Op2En         <= 1'b0;
      Op2RW         <= 2'b10;
    end else begin
      state <= next_state;

      // Completion of the transaction driven during the cycle that just ended.
      if_valid <= (state == FETCH);
      d_done   <= (state == DATA);
      if (state == FETCH)
        if_rdata <= Instruction;
      if ((state == DATA) && !Op2RW[0])
        d_rdata <= Data;

      Op2En <= (next_state == DATA) || (next_state == CLEAR);
      case (next_state)
        FETCH: ReadPC <= if_addr;
        DATA: begin
          ReadWriteAddr <= d_addr;
          DataWrite     <= d_wdata;
          Op2RW         <= {1'b1, d_we};
        end
        CLEAR: begin
          ReadWriteAddr <= clr_ptr;
          DataWrite     <= '0;
          Op2RW         <= 2'b00;
        end
        default: ;
      endcase

      if (!if_req || (next_state == FETCH))
        starve <= '0;
      else if ((next_state == DATA) || (next_state == CLEAR))
        starve <= starve + 1'b1;

      // The word is consumed at grant time, so a preempting data access never drops or repeats one.
      if (next_state == CLEAR) begin
        clr_ptr <= clr_ptr + 32'd1;
        clr_cnt <= clr_cnt - 1'b1;
        if (clr_cnt == LEN_W'(1))
          clr_busy <= 1'b0;
      end else if (clr_start && !clr_busy && (clr_len != '0)) begin
        clr_ptr  <= clr_base;
        clr_cnt  <= clr_len;
        clr_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level reference model predicts
// memory-side transactions and response pulses; a monitor compares them as they appear.
module tb_mem_port_arbiter;
  localparam int unsigned STARVE_MAX = 2;
  localparam int unsigned LEN_W      = 10;

  logic             clk;
  logic             reset;
  logic             if_req;
  logic [31:0]      if_addr;
  logic [31:0]      if_rdata;
  logic             if_valid;
  logic             d_req;
  logic             d_we;
  logic [31:0]      d_addr;
  logic [31:0]      d_wdata;
  logic [31:0]      d_rdata;
  logic             d_done;
  logic             clr_start;
  logic [31:0]      clr_base;
  logic [LEN_W-1:0] clr_len;
  logic             clr_busy;
  logic [31:0]      ReadPC;
  logic [31:0]      ReadWriteAddr;
  logic [31:0]      DataWrite;
  logic             Op2En;
  logic [1:0]       Op2RW;
  logic [31:0]      Instruction;
  logic [31:0]      Data;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len), .clr_busy(clr_busy),
    .ReadPC(ReadPC), .ReadWriteAddr(ReadWriteAddr), .DataWrite(DataWrite),
    .Op2En(Op2En), .Op2RW(Op2RW), .Instruction(Instruction), .Data(Data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [5:0] i);
    logic [31:0] v;
    v = 32'(i);
    return 32'hC0DE_0000 ^ (v * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'd4) return 32'h2002_000A;
    return (a * 32'h0100_0193) ^ 32'h1357_9BDF;
  endfunction

  // Memory behind the arbiter: 64 words aliased on the low address bits.
  bit [31:0] mem [64];
  bit        mem_wr [64];
  assign Instruction = instr_at(ReadPC);
  assign Data = mem_wr[ReadWriteAddr[5:0]] ? mem[ReadWriteAddr[5:0]] : init_word(ReadWriteAddr[5:0]);

  always @(posedge clk) begin
    if (Op2En && (Op2RW == 2'b11)) begin
      mem[ReadWriteAddr[5:0]]    <= DataWrite;
      mem_wr[ReadWriteAddr[5:0]] <= 1'b1;
    end else if (Op2En && (Op2RW == 2'b00)) begin
      mem[ReadWriteAddr[5:0]]    <= '0;
      mem_wr[ReadWriteAddr[5:0]] <= 1'b1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned stamp;
  } mem_exp_t;
  typedef struct {
    logic [31:0] val;
    int unsigned stamp;
  } resp_t;
  typedef enum {G_NONE, G_FETCH, G_DATA, G_CLEAR} grant_t;

  mem_exp_t    memq[$];
  resp_t       ifq[$];
  resp_t       dq[$];
  logic [31:0] clrq[$];
  bit [31:0]   mmem [64];
  bit          mmem_wr [64];
  logic [31:0] m_drdata;
  int unsigned m_starve;
  int unsigned cyc = 0;
  bit          exp_busy;
  grant_t      last_grant = G_NONE;
  bit          pend_valid;
  logic [5:0]  pend_idx;
  logic [31:0] pend_val;

  grant_t      g;
  bit          busy_before;
  logic [31:0] ca;
  mem_exp_t    me;
  resp_t       re;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      memq.delete(); ifq.delete(); dq.delete(); clrq.delete();
      m_starve = 0; m_drdata = '0; exp_busy = 0; last_grant = G_NONE; pend_valid = 0;
    end else begin
      // a write lands in memory when its access cycle completes
      if (pend_valid) begin
        mmem[pend_idx] = pend_val;
        mmem_wr[pend_idx] = 1'b1;
        pend_valid = 0;
      end
      busy_before = (clrq.size() != 0);
      if (if_req && (m_starve == STARVE_MAX)) g = G_FETCH;
      else if (d_req)                         g = G_DATA;
      else if (busy_before)                   g = G_CLEAR;
      else if (if_req)                        g = G_FETCH;
      else                                    g = G_NONE;
      m_starve = (!if_req || (g == G_FETCH)) ? 0 : m_starve + 1;
      case (g)
        G_FETCH: begin
          re.val = instr_at(if_addr); re.stamp = cyc + 1; ifq.push_back(re);
        end
        G_DATA: begin
          me.rw = {1'b1, d_we}; me.addr = d_addr; me.wdata = d_wdata; me.stamp = cyc;
          memq.push_back(me);
          if (d_we) begin
            pend_valid = 1; pend_idx = d_addr[5:0]; pend_val = d_wdata;
          end else begin
            m_drdata = mmem_wr[d_addr[5:0]] ? mmem[d_addr[5:0]] : init_word(d_addr[5:0]);
          end
          re.val = m_drdata; re.stamp = cyc + 1; dq.push_back(re);
        end
        G_CLEAR: begin
          ca = clrq.pop_front();
          me.rw = 2'b00; me.addr = ca; me.wdata = '0; me.stamp = cyc;
          memq.push_back(me);
          pend_valid = 1; pend_idx = ca[5:0]; pend_val = '0;
        end
        default: ;
      endcase
      if (clr_start && !busy_before && (clr_len != '0))
        for (int unsigned i = 0; i < 32'(clr_len); i++) clrq.push_back(clr_base + i);
      exp_busy = (clrq.size() != 0);
      last_grant = g;
    end
  end

  // ---------------- monitor ----------------
  mem_exp_t mm;
  resp_t    rr;
  bit       exp_on;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check32("clr_busy", 32'(clr_busy), 32'(exp_busy));
      exp_on = (memq.size() != 0) && (memq[0].stamp == cyc);
      check32("op2en", 32'(Op2En), 32'(exp_on));
      if (exp_on) begin
        mm = memq.pop_front();
        if (Op2En) begin
          check32("op2rw", 32'(Op2RW), 32'(mm.rw));
          check32("rwaddr", ReadWriteAddr, mm.addr);
          if (mm.rw == 2'b11) check32("datawrite", DataWrite, mm.wdata);
        end
      end
      exp_on = (ifq.size() != 0) && (ifq[0].stamp == cyc);
      check32("if_valid", 32'(if_valid), 32'(exp_on));
      if (exp_on) begin
        rr = ifq.pop_front();
        if (if_valid) check32("if_rdata", if_rdata, rr.val);
      end
      exp_on = (dq.size() != 0) && (dq[0].stamp == cyc);
      check32("d_done", 32'(d_done), 32'(exp_on));
      if (exp_on) begin
        rr = dq.pop_front();
        if (d_done) check32("d_rdata", d_rdata, rr.val);
      end
    end
  end

  // ---------------- stimulus ----------------
  int unsigned busy_cnt;
  int          first_v;

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    clr_start = 0; clr_base = '0; clr_len = '0;
    repeat (2) @(negedge clk);
    check32("rst_readpc", ReadPC, 32'h0);
    check32("rst_rwaddr", ReadWriteAddr, 32'h0);
    check32("rst_datawrite", DataWrite, 32'h0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check32("rst_op2rw", 32'(Op2RW), 32'h2);
    check32("rst_op2en", 32'(Op2En), 32'h0);
    check32("rst_busy", 32'(clr_busy), 32'h0);
    check32("rst_if_valid", 32'(if_valid), 32'h0);
    check32("rst_d_done", 32'(d_done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // single fetch
    if_req = 1; if_addr = 32'd4;
    @(negedge clk);
    check32("fetch_readpc", ReadPC, 32'd4);
    @(negedge clk);
    check32("fetch_valid", 32'(if_valid), 32'h1);
    check32("fetch_rdata", if_rdata, 32'h2002_000A);
    if_req = 0;
    repeat (3) @(negedge clk);

    // single write, then read it back
    d_req = 1; d_we = 1; d_addr = 32'd3; d_wdata = 32'h55;
    @(negedge clk);
    check32("wr_op2en", 32'(Op2En), 32'h1);
    check32("wr_op2rw", 32'(Op2RW), 32'h3);
    check32("wr_addr", ReadWriteAddr, 32'd3);
    check32("wr_data", DataWrite, 32'h55);
    d_req = 0;
    @(negedge clk);
    check32("wr_done", 32'(d_done), 32'h1);
    d_req = 1; d_we = 0; d_addr = 32'd3;
    @(negedge clk);
    d_req = 0;
    @(negedge clk);
    check32("rd_done", 32'(d_done), 32'h1);
    check32("rd_data", d_rdata, 32'h55);
    repeat (2) @(negedge clk);

    // clear 3 words at 8
    clr_start = 1; clr_base = 32'd8; clr_len = LEN_W'(3);
    @(negedge clk);
    clr_start = 0;
    busy_cnt = clr_busy ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("clr3_op2rw", 32'(Op2RW), 32'h0);
      check32("clr3_addr", ReadWriteAddr, 32'd8 + 32'(i));
      if (clr_busy) busy_cnt++;
    end
    repeat (3) begin
      @(negedge clk);
      if (clr_busy) busy_cnt++;
    end
    check32("clr3_busy_cycles", busy_cnt, 32'd3);

    // data held with fetch pending: DATA, DATA, FETCH repeating
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'd17;
    first_v = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check32("starve_pattern", 32'(Op2En), (i % 3 == 2) ? 32'h0 : 32'h1);
      if (if_valid && first_v < 0) first_v = i;
    end
    check32("starve_first_valid", 32'(first_v), 32'd3);
    if_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    // clear of 4 words preempted by a write after word 2
    clr_start = 1; clr_base = 32'd20; clr_len = LEN_W'(4);
    @(negedge clk);
    clr_start = 0;
    @(negedge clk);
    check32("pre_a0", ReadWriteAddr, 32'd20);
    @(negedge clk);
    check32("pre_a1", ReadWriteAddr, 32'd21);
    d_req = 1; d_we = 1; d_addr = 32'd40; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check32("pre_data_rw", 32'(Op2RW), 32'h3);
    d_req = 0;
    @(negedge clk);
    check32("pre_a2", ReadWriteAddr, 32'd22);
    @(negedge clk);
    check32("pre_a3", ReadWriteAddr, 32'd23);
    @(negedge clk);
    check32("pre_end", 32'(Op2En), 32'h0);

    // pointer wrap
    clr_start = 1; clr_base = 32'hFFFF_FFFE; clr_len = LEN_W'(3);
    @(negedge clk);
    clr_start = 0;
    @(negedge clk);
    check32("wrap_a0", ReadWriteAddr, 32'hFFFF_FFFE);
    @(negedge clk);
    check32("wrap_a1", ReadWriteAddr, 32'hFFFF_FFFF);
    @(negedge clk);
    check32("wrap_a2", ReadWriteAddr, 32'h0);
    repeat (2) @(negedge clk);

    // zero-length clear is ignored
    clr_start = 1; clr_base = 32'd5; clr_len = '0;
    @(negedge clk);
    clr_start = 0;
    check32("len0_busy", 32'(clr_busy), 32'h0);
    @(negedge clk);
    check32("len0_op2en", 32'(Op2En), 32'h0);

    // restart while busy is ignored (scoreboard expects only the first two words)
    clr_start = 1; clr_base = 32'd50; clr_len = LEN_W'(2);
    @(negedge clk);
    clr_base = 32'd100; clr_len = LEN_W'(5);
    @(negedge clk);
    clr_start = 0;
    repeat (6) @(negedge clk);

    // reset during word 2 of a 5-word clear
    clr_start = 1; clr_base = 32'd30; clr_len = LEN_W'(5);
    @(negedge clk);
    clr_start = 0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check32("rstmid_busy", 32'(clr_busy), 32'h0);
    check32("rstmid_op2en", 32'(Op2En), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check32("rstmid_no_clear", 32'(Op2En), 32'h0);
    end

    // randomized traffic; a requester keeps its request while an access is in flight
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (last_grant != G_FETCH) begin
        if_req  = (($urandom % 3) != 0);
        if_addr = $urandom;
      end
      if (last_grant != G_DATA) begin
        d_req   = (($urandom % 2) != 0);
        d_we    = 1'($urandom % 2);
        d_addr  = $urandom_range(0, 63);
        d_wdata = $urandom;
      end
      clr_start = (($urandom % 10) == 0);
      clr_base  = (($urandom % 4) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom_range(0, 63);
      clr_len   = LEN_W'($urandom_range(0, 6));
    end
    @(negedge clk);
    if_req = 0; d_req = 0; clr_start = 0;
    repeat (20) @(negedge clk);
    check32("drain_mem", 32'(memq.size()), 32'h0);
    check32("drain_if", 32'(ifq.size()), 32'h0);
    check32("drain_d", 32'(dq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 2: maximum number of consecutive non-fetch grants while if_req is pending.
REQ-002 Parameter LEN_W, default 10: width of the clear-length field.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch request; held until if_valid.
REQ-006 if_addr  in  32  fetch word address.
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_valid  out  1  one-cycle pulse: if_rdata is valid.
REQ-009 d_req  in  1  data request; held until d_done.
REQ-010 d_we  in  1  1 = write, 0 = read.
REQ-011 d_addr  in  32  data word address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_rdata  out  32  read data.
REQ-014 d_done  out  1  one-cycle pulse: data access completed.
REQ-015 clr_start  in  1  one-cycle pulse that starts a bulk clear.
REQ-016 clr_base  in  32  first data address to clear.
REQ-017 clr_len  in  LEN_W  number of words to clear; 0 = no-op.
REQ-018 clr_busy  out  1  high while a clear is in progress.
REQ-019 ReadPC  out  32  memory instruction address.
REQ-020 ReadWriteAddr  out  32  memory data address.
REQ-021 DataWrite  out  32  memory write data.
REQ-022 Op2En  out  1  memory data-port enable.
REQ-023 Op2RW  out  2  memory op: 10 = read, 11 = write, 00 = clear.
REQ-024 Instruction  in  32  memory instruction output.
REQ-025 Data  in  32  memory data output.

Function
REQ-026 The FSM SHALL have the states IDLE, FETCH, DATA and CLEAR; exactly one memory transaction SHALL be issued per non-IDLE cycle.
REQ-027 All memory-side outputs SHALL be registered; Op2En SHALL be 1 only in the DATA and CLEAR states.
REQ-028 Arbitration SHALL be evaluated on every edge where the FSM would otherwise return to IDLE, using priority data > clear > fetch.
REQ-029 A starvation counter SHALL count consecutive DATA/CLEAR grants while if_req=1; when the count equals STARVE_MAX, the next grant SHALL go to fetch; the counter SHALL clear on every FETCH grant and whenever if_req=0.
REQ-030 Latency: a request sampled at edge N SHALL drive the memory during cycle N..N+1; the result SHALL be captured and the done/valid pulse raised at edge N+1.
REQ-031 if_rdata SHALL latch Instruction, and d_rdata SHALL latch Data on reads; d_rdata SHALL hold its value on writes.
REQ-032 On FETCH, ReadPC = if_addr; on DATA, ReadWriteAddr = d_addr, DataWrite = d_wdata, and Op2RW = {1, d_we}.
REQ-033 ReadPC SHALL hold its last value outside FETCH, so the Instruction output stays stable.
REQ-034 clr_start SHALL latch clr_base and clr_len into an internal pointer and down-counter, and SHALL set clr_busy on the next edge.
REQ-035 clr_start with clr_len = 0 SHALL be ignored.
REQ-036 clr_start while clr_busy = 1 SHALL be ignored.
REQ-037 Each CLEAR grant SHALL issue Op2RW = 00 at the pointer address, then increment the pointer and decrement the counter; clr_busy SHALL drop on the edge at which the counter reaches 0.
REQ-038 The pointer SHALL wrap modulo 2^32.
REQ-039 A clear SHALL be preemptible word-by-word by data requests; words SHALL be neither lost nor repeated.
REQ-040 Back-to-back grants SHALL be allowed: a pending request SHALL be granted on the same edge the previous one completes, with no IDLE bubble.
REQ-041 A request deasserted before completion SHALL be a protocol violation; behaviour is undefined.
REQ-042 Simultaneous if_req, d_req and an active clear SHALL resolve per REQ-028 and REQ-029.

Reset
REQ-043 Reset SHALL force IDLE, clear the starvation counter, pointer and down-counter, and drive clr_busy=0, if_valid=0, d_done=0 and Op2En=0.
REQ-044 Reset SHALL drive Op2RW=10 and ReadPC=ReadWriteAddr=DataWrite=if_rdata=d_rdata=0.
REQ-045 Reset asserted mid-clear SHALL abort the clear; no further Op2RW=00 cycles SHALL be issued.

Verification
REQ-046 if_req=1, if_addr=4, Instruction=0x2002000A -> ReadPC=4 on the next edge; if_valid pulse with if_rdata=0x2002000A one edge later.
REQ-047 d_req=1, d_we=1, d_addr=3, d_wdata=0x55 -> one cycle with Op2En=1, Op2RW=11, ReadWriteAddr=3, DataWrite=0x55, then a d_done pulse.
REQ-048 clr_start with clr_base=8, clr_len=3 and no other requests -> Op2RW=00 at addresses 8, 9, 10 on consecutive cycles; clr_busy high for exactly 3 cycles.
REQ-049 d_req held continuously with if_req=1 -> pattern DATA, DATA, FETCH repeating; if_valid within 3 cycles.
REQ-050 Clear of 4 words with d_req injected after the 2nd word -> addresses base, base+1, DATA, base+2, base+3.
REQ-051 Reset asserted during clear word 2 of 5 -> clr_busy=0 and Op2En=0 immediately; no further clears after reset deasserts.
